// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and helpers for the LFSR sequencing controller and its arbiter.
package lfsr_seq_ctrl_pkg;

    localparam int unsigned LFSR_W_DEF    = 5;
    localparam int unsigned LFSR_MAXB_DEF = 8;
    localparam int unsigned NBITS_W       = 4;
    localparam int unsigned NREQ          = 2;

    typedef enum logic [2:0] {
        ST_UNSEEDED = 3'd0,
        ST_SEED     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

    // A request of zero bits, or more than the collector holds, means a full word.
    function automatic int unsigned clamp_nbits(input logic [NBITS_W-1:0] nbits,
                                                input int unsigned        maxb);
        int unsigned req;
        req = 32'(nbits);
        if ((req == 0) || (req > maxb)) begin
            return maxb;
        end
        return req;
    endfunction

endpackage

// File: rtl/lfsr_rr_arb2.sv
// Two-way round-robin grant; the priority pointer only moves when a response completes.
module lfsr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       done_i,
    output logic [1:0] gnt_o_c,
    output logic       gnt_id_o_c
);

    logic ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (done_i) begin
            ptr_q <= ~ptr_q;
        end
    end

    // The pointed-to requester wins; otherwise the other one, if it asks.
    always_comb begin
        gnt_id_o_c = req_i[ptr_q] ? ptr_q : ~ptr_q;
        gnt_o_c    = 2'b00;
        if (en_i && (|req_i)) begin
            gnt_o_c = gnt_id_o_c ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for an external LFSR: reseed handshake plus two
// round-robin requesters that each collect up to MAXB bits of lfsr_out.
module lfsr_seq_ctrl
    import lfsr_seq_ctrl_pkg::*;
#(
    parameter int unsigned W    = LFSR_W_DEF,
    parameter int unsigned MAXB = LFSR_MAXB_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [W-1:0]       cfg_seed,
    input  logic [W-1:0]       cfg_taps,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NBITS_W-1:0] req_nbits_0,
    input  logic [NBITS_W-1:0] req_nbits_1,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [MAXB-1:0]    resp_data,
    output logic               lfsr_reinit,
    output logic               lfsr_advance,
    output logic [W-1:0]       lfsr_initial_state,
    output logic [W-1:0]       lfsr_taps,
    input  logic               lfsr_out
);

    localparam int unsigned CNT_W = $clog2(MAXB + 1);

    seq_state_e state_q, state_d;

    logic [W-1:0]     seed_q, seed_d;
    logic [W-1:0]     taps_q, taps_d;
    logic [MAXB-1:0]  coll_q, coll_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic             id_q, id_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
    logic             reinit_q, reinit_d;
    logic             advance_q, advance_d;

    logic               cfg_take_c;
    logic               grant_en_c;
    logic               run_last_c;
    logic               resp_hs_c;
    logic [NREQ-1:0]    gnt_c;
    logic               gnt_id_c;
    logic [NBITS_W-1:0] gnt_nbits_c;

    // A zero seed is accepted but ignored; a real reseed beats any request.
    assign cfg_take_c  = cfg_valid && cfg_ready_q && (cfg_seed != '0);
    assign grant_en_c  = (state_q == ST_IDLE) && !cfg_take_c && !rst;
    assign run_last_c  = (cnt_q == (nbits_q - CNT_W'(1)));
    assign resp_hs_c   = (state_q == ST_DONE) && resp_ready[id_q];
    assign gnt_nbits_c = gnt_id_c ? req_nbits_1 : req_nbits_0;

    lfsr_rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_valid),
        .en_i       (grant_en_c),
        .done_i     (resp_hs_c),
        .gnt_o_c    (gnt_c),
        .gnt_id_o_c (gnt_id_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNSEEDED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_UNSEEDED: if (cfg_take_c) state_d = ST_SEED;
            ST_SEED:     state_d = ST_IDLE;
            ST_IDLE: begin
                if (cfg_take_c) begin
                    state_d = ST_SEED;
                end else if (|gnt_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:      if (run_last_c) state_d = ST_DONE;
            ST_DONE:     if (resp_hs_c) state_d = ST_IDLE;
            default:     state_d = ST_UNSEEDED;
        endcase
    end

    // Datapath next values and state-decoded outputs, registered below.
    always_comb begin
        seed_d  = seed_q;
        taps_d  = taps_q;
        id_d    = id_q;
        nbits_d = nbits_q;
        cnt_d   = cnt_q;
        coll_d  = coll_q;

        if (cfg_take_c) begin
            seed_d = cfg_seed;
            taps_d = cfg_taps;
        end

        if (|gnt_c) begin
            id_d    = gnt_id_c;
            nbits_d = CNT_W'(clamp_nbits(gnt_nbits_c, MAXB));
            cnt_d   = '0;
            coll_d  = '0;
        end

        if (state_q == ST_RUN) begin
            coll_d = coll_q | (MAXB'(lfsr_out) << cnt_q);
            cnt_d  = cnt_q + CNT_W'(1);
        end

        cfg_ready_d  = (state_d == ST_UNSEEDED) || (state_d == ST_IDLE);
        reinit_d     = (state_d == ST_SEED);
        advance_d    = (state_d == ST_RUN);
        resp_valid_d = (state_d == ST_DONE) ? (id_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q       <= '0;
            taps_q       <= '0;
            id_q         <= 1'b0;
            nbits_q      <= '0;
            cnt_q        <= '0;
            coll_q       <= '0;
            cfg_ready_q  <= 1'b0;
            reinit_q     <= 1'b0;
            advance_q    <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            seed_q       <= seed_d;
            taps_q       <= taps_d;
            id_q         <= id_d;
            nbits_q      <= nbits_d;
            cnt_q        <= cnt_d;
            coll_q       <= coll_d;
            cfg_ready_q  <= cfg_ready_d;
            reinit_q     <= reinit_d;
            advance_q    <= advance_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // req_ready must answer req_valid in the same cycle, so it is the one combinational output.
    assign req_ready          = gnt_c;
    assign cfg_ready          = cfg_ready_q;
    assign resp_valid         = resp_valid_q;
    assign resp_data          = coll_q;
    assign lfsr_reinit        = reinit_q;
    assign lfsr_advance       = advance_q;
    assign lfsr_initial_state = seed_q;
    assign lfsr_taps          = taps_q;

endmodule
